// File: rtl/mdu_divider_pkg.sv
// rtl/mdu_divider_pkg.sv - shared constants, FSM state type and helpers for the RV32M divider
package mdu_divider_pkg;

  // Operand/result width; the datapath is only built for 32.
  localparam int XLEN  = 32;
  // Iteration counter width; must be able to hold XLEN.
  localparam int CNT_W = 6;

  // Divide-unit ALU control codes, disjoint from the multiply codes.
  localparam logic [3:0] MALU_DIV  = 4'd4;
  localparam logic [3:0] MALU_DIVU = 4'd5;
  localparam logic [3:0] MALU_REM  = 4'd6;
  localparam logic [3:0] MALU_REMU = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  // Map any unrecognised control code onto DIVU so the unit always completes.
  function automatic logic [3:0] norm_op(input logic [3:0] op);
    logic [3:0] res;
    case (op)
      MALU_DIV, MALU_DIVU, MALU_REM, MALU_REMU: res = op;
      default:                                  res = MALU_DIVU;
    endcase
    return res;
  endfunction

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == MALU_DIV) || (op == MALU_REM);
  endfunction

  function automatic logic op_is_rem(input logic [3:0] op);
    return (op == MALU_REM) || (op == MALU_REMU);
  endfunction

  // Two's-complement magnitude when neg is set; 0x8000_0000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mdu_divider_core.sv
// rtl/mdu_divider_core.sv - 32-step restoring division on unsigned magnitudes
module div_restoring_core
  import mdu_divider_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o,
  output logic            last_o
);

  logic [XLEN:0]    rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  div_q;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN+1:0]  shifted;
  logic [XLEN+1:0]  diff;

  // Trial subtraction of the divisor from the left-shifted partial remainder;
  // one extra bit above the remainder register carries the sign of the trial.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {2'b00, div_q};
  end

  // Load fresh magnitudes, or perform one restoring step per cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      div_q <= divisor_i;
      cnt_q <= '0;
    end else if (step_i) begin
      if (!diff[XLEN+1]) begin
        rem_q <= diff[XLEN:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign quo_o  = quo_q;
  assign rem_o  = rem_q[XLEN-1:0];
  assign last_o = (cnt_q == CNT_W'(XLEN - 1));

endmodule

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit with pipeline stall
module mdu_divider
  import mdu_divider_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [3:0]  ALU_Ctrl_i,
  input  logic [31:0] data0_i,
  input  logic [31:0] data1_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] data_o
);

  div_state_t      state_q;
  logic [3:0]      op_q;
  logic            neg_a_q;
  logic            neg_b_q;

  logic [3:0]      in_op;
  logic            in_signed;
  logic            in_neg_a;
  logic            in_neg_b;
  logic [XLEN-1:0] in_a_mag;
  logic [XLEN-1:0] in_b_mag;
  logic            in_div0;
  logic [XLEN-1:0] in_div0_res;

  logic            core_load;
  logic            core_step;
  logic [XLEN-1:0] core_quo;
  logic [XLEN-1:0] core_rem;
  logic            core_last;

  logic [XLEN-1:0] fix_quo;
  logic [XLEN-1:0] fix_rem;
  logic [XLEN-1:0] fix_res;

  // Decode the incoming request: operation, operand signs and magnitudes.
  always_comb begin
    in_op       = norm_op(ALU_Ctrl_i);
    in_signed   = op_is_signed(in_op);
    in_neg_a    = in_signed & data0_i[XLEN-1];
    in_neg_b    = in_signed & data1_i[XLEN-1];
    in_a_mag    = mag(data0_i, in_neg_a);
    in_b_mag    = mag(data1_i, in_neg_b);
    in_div0     = (data1_i == '0);
    in_div0_res = op_is_rem(in_op) ? data0_i : '1;
  end

  assign core_load = (state_q == ST_IDLE) & start_i & ~flush_i & ~in_div0;
  assign core_step = (state_q == ST_CALC) & ~flush_i;

  div_restoring_core u_core (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (core_load),
    .step_i     (core_step),
    .dividend_i (in_a_mag),
    .divisor_i  (in_b_mag),
    .quo_o      (core_quo),
    .rem_o      (core_rem),
    .last_o     (core_last)
  );

  // Sign fix: the quotient is negative when operand signs differ, the
  // remainder takes the sign of the dividend. Overflow falls out naturally.
  always_comb begin
    fix_quo = (neg_a_q ^ neg_b_q) ? (~core_quo + 1'b1) : core_quo;
    fix_rem = neg_a_q ? (~core_rem + 1'b1) : core_rem;
    fix_res = op_is_rem(op_q) ? fix_rem : fix_quo;
  end

  // Control FSM with registered busy/done/result; flush aborts from any state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      data_o  <= '0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            op_q    <= in_op;
            neg_a_q <= in_neg_a;
            neg_b_q <= in_neg_b;
            if (in_div0) begin
              data_o  <= in_div0_res;
              done_o  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              busy_o  <= 1'b1;
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (core_last) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          data_o  <= fix_res;
          busy_o  <= 1'b0;
          done_o  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_o  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall_o = busy_o | (start_i & (state_q == ST_IDLE) & ~flush_i);

endmodule

// File: tb/tb_mdu_divider.sv
// tb/tb_mdu_divider.sv - self-checking bench for mdu_divider
module tb_mdu_divider;

  logic        clk_i;
  logic        rst_n_i;
  logic        start_i;
  logic [3:0]  ALU_Ctrl_i;
  logic [31:0] data0_i;
  logic [31:0] data1_i;
  logic        flush_i;
  logic        busy_o;
  logic        stall_o;
  logic        done_o;
  logic [31:0] data_o;

  mdu_divider dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .ALU_Ctrl_i (ALU_Ctrl_i),
    .data0_i    (data0_i),
    .data1_i    (data1_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .data_o     (data_o)
  );

  localparam int NEVER = 1 << 30;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  bit chk_en = 0;

  // Expected timeline of the operation in flight, in absolute cycle numbers.
  int          b_lo = NEVER;
  int          b_hi = -1;
  int          d_at = -1;
  int          sw   = NEVER;
  logic [31:0] cur_data = '0;
  logic [31:0] new_data = '0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[13];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // RV32M reference semantics in plain arithmetic.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [3:0]  o;
    logic        ovf;
    logic [31:0] r;
    o   = (op >= 4'd4 && op <= 4'd7) ? op : 4'd5;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      4'd4:    r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      4'd6:    r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      4'd7:    r = (b == 0) ? a : a % b;
      default: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
    endcase
    return r;
  endfunction

  // Per-cycle comparison of all outputs against the expected timeline.
  always @(negedge clk_i) begin
    if (chk_en) begin
      logic e_busy, e_done, e_stall;
      e_busy  = (cyc >= b_lo) && (cyc <= b_hi);
      e_done  = (cyc == d_at);
      e_stall = e_busy | (start_i & ~e_busy & ~e_done & ~flush_i);
      chk("busy_o", 32'(busy_o), 32'(e_busy));
      chk("done_o", 32'(done_o), 32'(e_done));
      chk("stall_o", 32'(stall_o), 32'(e_stall));
      chk("data_o", data_o, (cyc >= sw) ? new_data : cur_data);
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Issue one operation and follow it to completion; optionally poke start mid-flight.
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] want, input bit poke);
    int c0;
    logic [31:0] m;
    m = model(op, a, b);
    chk("model_pin", m, want);
    c0 = cyc;
    start_i = 1'b1; ALU_Ctrl_i = op; data0_i = a; data1_i = b;
    if (b == 0) begin
      b_lo = NEVER; b_hi = -1; d_at = c0 + 1;
    end else begin
      b_lo = c0 + 1; b_hi = c0 + 33; d_at = c0 + 34;
    end
    new_data = m;
    sw = d_at;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    if (poke && b != 0) begin
      wait_cyc(c0 + 5);
      start_i = 1'b1; ALU_Ctrl_i = 4'd4; data0_i = 32'd999; data1_i = 32'd0;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
    end
    wait_cyc(d_at + 1);
    chk("result", data_o, want);
    cur_data = m;
    sw = NEVER;
  endtask

  initial begin
    vecs = '{
      '{4'd4, 32'h0000_0014, 32'hFFFF_FFFD, 32'hFFFF_FFFA},
      '{4'd6, 32'h0000_0014, 32'hFFFF_FFFD, 32'h0000_0002},
      '{4'd6, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE},
      '{4'd7, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005},
      '{4'd5, 32'hFFFF_FFFF, 32'h0000_0002, 32'h7FFF_FFFF},
      '{4'd5, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000},
      '{4'd4, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF},
      '{4'd6, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007},
      '{4'd7, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000},
      '{4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
      '{4'd9, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E},
      '{4'd4, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2}
    };

    rst_n_i = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    ALU_Ctrl_i = '0; data0_i = '0; data1_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    rst_n_i = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, i == 0);
    end

    // Flush together with a start in IDLE: the start is dropped.
    start_i = 1'b1; flush_i = 1'b1; ALU_Ctrl_i = 4'd4; data0_i = 32'd9; data1_i = 32'd0;
    @(posedge clk_i);
    #1;
    start_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;

    // Flush during cycle 10 of a DIVU: idle at cycle 11, no done, data kept.
    begin
      int c0;
      c0 = cyc;
      start_i = 1'b1; ALU_Ctrl_i = 4'd5; data0_i = 32'd1000; data1_i = 32'd3;
      b_lo = c0 + 1; b_hi = c0 + 10; d_at = -1; sw = NEVER;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      wait_cyc(c0 + 10);
      flush_i = 1'b1;
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      wait_cyc(c0 + 45);
      chk("flush_data", data_o, 32'hFFFF_FFF2);
    end

    run(4'd5, 32'h0000_0064, 32'h0000_0003, 32'h0000_0021, 1'b0);

    // Reset dropped at cycle 20 of an operation: outputs clear asynchronously.
    begin
      int c0;
      c0 = cyc;
      start_i = 1'b1; ALU_Ctrl_i = 4'd5; data0_i = 32'hFFFF_FFFF; data1_i = 32'd3;
      b_lo = c0 + 1; b_hi = c0 + 20; d_at = -1; sw = NEVER;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      wait_cyc(c0 + 20);
      #2;
      chk_en = 1'b0;
      rst_n_i = 1'b0;
      #1;
      chk("arst_busy", 32'(busy_o), 32'd0);
      chk("arst_done", 32'(done_o), 32'd0);
      chk("arst_stall", 32'(stall_o), 32'd0);
      chk("arst_data", data_o, 32'd0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      cur_data = '0; b_lo = NEVER; b_hi = -1; d_at = -1; sw = NEVER;
      chk_en = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
    end

    run(4'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0);
    run(4'd4, 32'h0000_0014, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
